// File: rtl/board_pkg.sv
// Board-wide constants shared by the Boolean-board input-conditioning logic.
//   SW_WIDTH        : number of slide switches on the board
//   CLK_HZ          : system clock frequency
//   DEBOUNCE_MS     : switch settle window in milliseconds
//   DEBOUNCE_CYCLES : settle window expressed in clk cycles
package board_pkg;

  localparam int unsigned SW_WIDTH        = 8;
  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bus between the raw pins and the debouncer.
//   sw_raw  : raw switch pins (asynchronous to clk), driven by the master
//   sw_db   : debounced, registered levels, driven by the slave
//   sw_rise : one-cycle pulse per bit when sw_db goes 0->1
//   sw_fall : one-cycle pulse per bit when sw_db goes 1->0
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (output sw_raw, input  sw_db, sw_rise, sw_fall);
  modport slave  (input  sw_raw, output sw_db, sw_rise, sw_fall);

endinterface

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced
// level flop and registered rise/fall event pulses.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   i_sw_raw   : raw switch pin (asynchronous)
//   o_sw_db    : debounced level
//   o_sw_rise  : one-cycle pulse when o_sw_db goes 0->1
//   o_sw_fall  : one-cycle pulse when o_sw_db goes 1->0
module debounce_channel #(
  parameter int unsigned STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw_raw,
  output logic o_sw_db,
  output logic o_sw_rise,
  output logic o_sw_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_sw_raw;
      r_sync1 <= r_sync0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync1 == r_db) begin
        // Level agrees with the output (idle, or a bounce back): restart window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db   <= r_sync1;
        r_rise <= r_sync1;
        r_fall <= ~r_sync1;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sw_db   = r_db;
  assign o_sw_rise = r_rise;
  assign o_sw_fall = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// Input-conditioning stage for the slide-switch bus: synchronises every
// switch into the clk domain, rejects contact bounce and emits per-bit
// rise/fall event pulses. Channels are fully independent.
//   clk  : system clock (100 MHz on board)
//   rst  : synchronous, active-high reset
//   bus  : switch bus (slave side) - sw_raw in; sw_db, sw_rise, sw_fall out
module switch_debouncer
  import board_pkg::*;
#(
  parameter int unsigned WIDTH         = SW_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  switch_debouncer_if.slave    bus
);

  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_sw_raw  (bus.sw_raw[i]),
      .o_sw_db   (w_db[i]),
      .o_sw_rise (w_rise[i]),
      .o_sw_fall (w_fall[i])
    );
  end

  assign bus.sw_db   = w_db;
  assign bus.sw_rise = w_rise;
  assign bus.sw_fall = w_fall;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the Boolean-board combinational logic blocks.
- Takes the raw asynchronous slide-switch bus, synchronises each bit into the system clock domain, and suppresses contact bounce.
- Presents a clean, registered switch bus (sw_db) that the downstream logic consumes in place of raw pins.
- Also emits one-cycle rise/fall event pulses per bit for future sequential consumers (counters, FSMs).

Parameters:
- WIDTH, 8, number of switch channels.
- STABLE_CYCLES, 1000000, consecutive clock cycles a synchronised level must differ from sw_db before it is accepted. The default gives 10 ms at 100 MHz. Legal range is ≥1.
- CNT_W, $clog2(STABLE_CYCLES+1), counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock, 100 MHz on board.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- sw_db  output  WIDTH  debounced, registered switch levels.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0→1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1→0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk only.
- Reset values:
  - sw_db, sw_rise, sw_fall = 0.
  - Both synchroniser flops = 0.
  - All counters = 0.
  - rst has priority over every other event.
- Channels are fully independent. Per bit i:
  - Synchroniser: 2 flops, sync0 ← sw_raw[i], then sync1 ← sync0. Only sync1 is used downstream.
  - IDLE (sync1 == sw_db[i]): counter held at 0.
  - COUNTING (sync1 != sw_db[i]):
    - If cnt == STABLE_CYCLES-1: sw_db[i] ← sync1, cnt ← 0, and the matching rise or fall pulse asserts for that cycle.
    - Otherwise cnt ← cnt+1.
  - If sync1 returns to equal sw_db[i] before commit: cnt ← 0 on that edge, with no output change. Any bounce restarts the full window.
- Latency: for a clean step whose first sampling edge is edge 1, sw_db[i] changes on edge STABLE_CYCLES+2. There is no earlier change under any stimulus.
- Glitch rejection: a raw pulse held for fewer than STABLE_CYCLES cycles is never propagated. One held for ≥STABLE_CYCLES cycles is propagated.
- Pulses:
  - sw_rise/sw_fall are registered and high for exactly one cycle, aligned with the edge on which sw_db changes.
  - Rise and fall are never both high for the same bit.
  - Different bits may pulse in the same cycle.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Reset mid-count: all progress is discarded. After rst deasserts, a held-high input re-qualifies in STABLE_CYCLES+2 edges and produces a sw_rise pulse.
- Power-on with a switch already high: sw_db bit rises after STABLE_CYCLES+2 edges with a rise pulse. Downstream treats this as a normal event.
- STABLE_CYCLES=1: a commit occurs on the first COUNTING cycle.

Decomposition:
- Shared package board_pkg:
  - SW_WIDTH = 8.
  - CLK_HZ = 100000000.
  - DEBOUNCE_MS = 10.
  - Derived DEBOUNCE_CYCLES, used as the STABLE_CYCLES default at integration.
- One natural sub-module, debounce_channel. It holds one bit's synchroniser, counter, db flop and rise/fall pulse flops. switch_debouncer instantiates WIDTH copies in a generate loop.
- No typedefs are needed; the per-channel state is implied by the sync1/sw_db compare.

Test Plan:
All tests run with STABLE_CYCLES=4, so a clean step commits on edge 6.
1. Reset and quiet input: rst high 2 cycles, then sw_raw=0x00 for 100 cycles → sw_db=0x00, sw_rise=sw_fall=0x00 throughout.
2. Clean step: sw_raw 0x00→0x01 before edge 1 → sw_db=0x01 first visible after edge 6. sw_rise=0x01 for exactly that one cycle. No other bit changes and no sw_fall.
3. Glitch boundary on bit 3, from sw_db=0x00:
   - A 3-cycle high pulse → sw_db stays 0x00 and no pulse.
   - A 4-cycle high pulse → sw_db[3]=1, then later returns to 0 after the low level is held 4+ cycles, with rise and fall pulses each for one cycle.
4. Multi-bit simultaneous change:
   - sw_raw 0x00→0xA5 → sw_db=0xA5 on edge 6 and sw_rise=0xA5 for one cycle.
   - Then 0xA5→0x5A → sw_db=0x5A on one edge, with sw_rise=0x5A and sw_fall=0xA5 in the same cycle.
5. Reset mid-count: sw_raw[7]=1, rst pulsed for one cycle at edge 3 → sw_db=0x00. sw_db[7]=1 with a sw_rise[7] pulse exactly 6 edges after rst deasserts.
6. Continuous bounce: toggle sw_raw[0] every 2 cycles for 200 cycles, then hold 1 → no sw_db change during bouncing. Commit occurs 6 edges after the final transition.
